pwm_output_controller: RTL and testbench

Drives the 16 chip outputs from the configuration registers written over SPI: per-bit static enables, per-bit PWM select, and a shared 8-bit duty cycle. It owns the PWM time base (clock prescaler plus 8-bit period counter) and double-buffers the duty cycle so that SPI writes never produce a glitched PWM period. It sits between the SPI register bank and the output pads, and is the only block that sequences the output drivers.

---
 rtl/pwm_output_controller.sv | 72 +++++++
 tb/tb_pwm_output_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_output_controller.sv
// PWM output controller: drives 16 output pads from the SPI enable and duty registers.
// Owns the PWM time base and double-buffers the duty cycle so that no period is ever glitched.
module pwm_output_controller #(
    parameter int CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [7:0]       cnt;
    logic [7:0]       duty_sh;
    logic [7:0]       duty_eff;
    logic             tick;
    logic             boundary;
    logic             pwm_high;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [15:0]      out_next;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        en_out   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        tick     = (pre == PRE_MAX);
        boundary = (cnt == 8'd0) && (pre == '0);
        // On the boundary cycle the fresh duty is used directly, so a write that lands
        // on that exact cycle takes effect from the very first cycle of the period.
        duty_eff = boundary ? pwm_duty_cycle : duty_sh;
        // 0xFF is forced high so the output has no one-step low gap at the wrap.
        pwm_high = (duty_eff == 8'hFF) || (cnt < duty_eff);
        out_next = '0;
        for (int i = 0; i < 16; i++) begin
            if (en_out[i]) begin
                out_next[i] = en_pwm[i] ? pwm_high : 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre          <= '0;
            cnt          <= 8'd0;
            duty_sh      <= 8'd0;
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            if (boundary) begin
                duty_sh <= pwm_duty_cycle;
            end
            out          <= out_next;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_output_controller.sv
// Scoreboard bench for pwm_output_controller with CLK_DIV=4 (1024-clock PWM period).
// Stimulus queues per-cycle expectations; a monitor on the falling edge pops and compares.
module tb_pwm_output_controller;

    localparam int CD  = 4;
    localparam int PER = 256 * CD;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    pwm_output_controller #(.CLK_DIV(CD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges since reset release; after edge n the outputs reflect cycle n-1.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [15:0] out;
        logic        ps;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc=%0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    // Queue expectations for edges n0..n1 with a fixed enable set and the duty active in that span.
    task automatic push_seg(int n0, int n1, logic [15:0] eo, logic [15:0] ep,
                            logic [7:0] d, string nm);
        exp_t e;
        for (int n = n0; n <= n1; n++) begin
            int   dc;
            int   step;
            logic hi;
            dc   = n - 1;
            step = (dc / CD) % 256;
            hi   = (d == 8'hFF) || (step < int'(d));
            e.cyc  = n;
            e.ps   = ((dc % PER) == 0);
            e.name = nm;
            for (int i = 0; i < 16; i++) begin
                if (!eo[i])     e.out[i] = 1'b0;
                else if (ep[i]) e.out[i] = hi;
                else            e.out[i] = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("wait_cyc", cyc, n);
    endtask

    task automatic set_en(logic [15:0] eo, logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    // Monitor: compares every queued expectation on the falling edge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    check({e.name, "_missed"}, cyc, e.cyc);
                end else begin
                    check({e.name, "_out"}, {16'h0, out}, {16'h0, e.out});
                    check({e.name, "_ps"}, {31'h0, period_start}, {31'h0, e.ps});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_en(16'hA55A, 16'h0000);
        pwm_duty_cycle = 8'h00;
        #1;
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_ps", {31'h0, period_start}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Static enables, then a single-bit change one cycle later.
        push_seg(1, 20, 16'hA55A, 16'h0000, 8'h00, "static_a55a");
        wait_cyc(20);
        set_en(16'h0001, 16'h0000);
        push_seg(21, 30, 16'h0001, 16'h0000, 8'h00, "static_0001");

        // Duty 0x40 from period 1; 0xC0 written at cnt=0x10 of period 2 lands in period 3.
        wait_cyc(30);
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        push_seg(31, 1024, 16'hFFFF, 16'hFFFF, 8'h00, "p0_duty0");
        push_seg(1025, 3072, 16'hFFFF, 16'hFFFF, 8'h40, "duty40");
        wait_cyc(2 * PER + 16 * CD);
        pwm_duty_cycle = 8'hC0;
        push_seg(3073, 4200, 16'hFFFF, 16'hFFFF, 8'hC0, "dbuf_c0");

        // Endpoints: duty 0x00 for periods 5..7, then 0xFF for periods 8..10.
        wait_cyc(4200);
        pwm_duty_cycle = 8'h00;
        push_seg(4201, 5120, 16'hFFFF, 16'hFFFF, 8'hC0, "c0_tail");
        push_seg(5121, 8192, 16'hFFFF, 16'hFFFF, 8'h00, "duty00");
        wait_cyc(7200);
        pwm_duty_cycle = 8'hFF;
        push_seg(8193, 10300, 16'hFFFF, 16'hFFFF, 8'hFF, "dutyff");

        // Mixed mode: enables apply immediately, duty 0x80 from period 11.
        wait_cyc(10300);
        set_en(16'h00FF, 16'h000F);
        pwm_duty_cycle = 8'h80;
        push_seg(10301, 11264, 16'h00FF, 16'h000F, 8'hFF, "mixed_ff");
        push_seg(11265, 13312, 16'h00FF, 16'h000F, 8'h80, "mixed_80");

        // Mid-period asynchronous reset with all outputs driven high.
        wait_cyc(13312);
        set_en(16'hFFFF, 16'hFFFF);
        push_seg(13313, 13500, 16'hFFFF, 16'hFFFF, 8'h80, "pre_rst");
        wait_cyc(13500);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", {16'h0, out}, 32'h0);
        check("async_rst_ps", {31'h0, period_start}, 32'h0);
        check("async_rst_sb", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_seg(1, 8, 16'hFFFF, 16'hFFFF, 8'h80, "post_rst");
        wait_cyc(8);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
